// File: rtl/microcode_sequencer_if.sv
// Microcode ROM bus between the sequencer and its asynchronous ROM.
//   rom_addr : {routine, step} address presented by the sequencer
//   rom_data : {END, control word} returned combinationally by the ROM
// Modports: master = sequencer side, slave = ROM side.
interface microcode_sequencer_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    modport master (output rom_addr, input  rom_data);
    modport slave  (input  rom_addr, output rom_data);
endinterface

// File: rtl/microcode_sequencer.sv
// Microcode sequencer for the 65C02 core: walks an addressed microcode ROM
// with a step counter, selects the next routine (RESET / NMI / IRQ / opcode)
// at each routine end and registers the control word that feeds the core.
// Ports:
//   fclk, reset       : clock, asynchronous active-high reset
//   clock_running     : advance enable (0 = stall, sequencing state holds)
//   opcode            : instruction byte, sampled at routine end
//   nmi_req           : NMI request, rising-edge sensitive
//   irq_req, irq_mask : level IRQ request and I-flag mask
//   rom               : ROM bus (rom_addr out, rom_data in, bit CW_WIDTH = END)
//   control_word      : registered control word
//   routine, step     : current routine index and micro-step
//   sync              : high while executing step 0 of an opcode routine
//   nmi_taken         : one-cycle pulse on entry to the NMI routine
//   ucode_err         : sticky, a routine ran past its last step without END
module microcode_sequencer #(
    parameter int                  OP_BITS   = 8,
    parameter int                  STEP_BITS = 4,
    parameter int                  CW_WIDTH  = 63,
    parameter logic [CW_WIDTH-1:0] CW_IDLE   = '0
) (
    input  logic                     fclk,
    input  logic                     reset,
    input  logic                     clock_running,
    input  logic [OP_BITS-1:0]       opcode,
    input  logic                     nmi_req,
    input  logic                     irq_req,
    input  logic                     irq_mask,
    microcode_sequencer_if.master    rom,
    output logic [CW_WIDTH-1:0]      control_word,
    output logic [OP_BITS:0]         routine,
    output logic [STEP_BITS-1:0]     step,
    output logic                     sync,
    output logic                     nmi_taken,
    output logic                     ucode_err
);
    localparam int R_W = OP_BITS + 1;

    localparam logic [R_W-1:0]       RT_RESET = {1'b1, {OP_BITS{1'b0}}};
    localparam logic [R_W-1:0]       RT_NMI   = RT_RESET | R_W'(1);
    localparam logic [R_W-1:0]       RT_IRQ   = RT_RESET | R_W'(2);
    localparam logic [STEP_BITS-1:0] STEP_MAX = '1;

    logic [R_W-1:0]       routine_q, routine_d;
    logic [STEP_BITS-1:0] step_q, step_d;
    logic [CW_WIDTH-1:0]  cw_q, cw_d;
    logic                 sync_q, sync_d;
    logic                 nmi_taken_q, nmi_taken_d;
    logic                 err_q, err_d;
    logic                 nmi_pend_q, nmi_pend_d;
    logic                 nmi_prev_q;

    logic                 rom_end;
    logic                 at_max;
    logic                 routine_end;
    logic [R_W-1:0]       next_routine;

    // State register
    always_ff @(posedge fclk or posedge reset) begin
        if (reset) begin
            routine_q   <= RT_RESET;
            step_q      <= '0;
            cw_q        <= CW_IDLE;
            sync_q      <= 1'b0;
            nmi_taken_q <= 1'b0;
            err_q       <= 1'b0;
            nmi_pend_q  <= 1'b0;
            nmi_prev_q  <= 1'b0;
        end else begin
            routine_q   <= routine_d;
            step_q      <= step_d;
            cw_q        <= cw_d;
            sync_q      <= sync_d;
            nmi_taken_q <= nmi_taken_d;
            err_q       <= err_d;
            nmi_pend_q  <= nmi_pend_d;
            // Edge history runs every fclk so NMI edges during a stall are kept.
            nmi_prev_q  <= nmi_req;
        end
    end

    // Next-state logic
    always_comb begin
        rom_end     = rom.rom_data[CW_WIDTH];
        at_max      = (step_q == STEP_MAX);
        routine_end = rom_end | at_max;

        if (nmi_pend_q)
            next_routine = RT_NMI;
        else if (irq_req & ~irq_mask)
            next_routine = RT_IRQ;
        else
            next_routine = {1'b0, opcode};

        routine_d   = routine_q;
        step_d      = step_q;
        cw_d        = cw_q;
        sync_d      = sync_q;
        nmi_taken_d = nmi_taken_q;
        err_d       = err_q;

        if (clock_running) begin
            cw_d = rom.rom_data[CW_WIDTH-1:0];
            if (routine_end) begin
                step_d      = '0;
                routine_d   = next_routine;
                sync_d      = ~next_routine[OP_BITS];
                nmi_taken_d = nmi_pend_q;
                if (at_max & ~rom_end)
                    err_d = 1'b1;
            end else begin
                step_d      = step_q + 1'b1;
                sync_d      = 1'b0;
                nmi_taken_d = 1'b0;
            end
        end

        // NMI is entered exactly when a pending request meets an enabled
        // routine end; a fresh edge on that same cycle re-arms the request.
        nmi_pend_d = (nmi_req & ~nmi_prev_q)
                   | (nmi_pend_q & ~(clock_running & routine_end));
    end

    // Outputs
    always_comb begin
        rom.rom_addr = {routine_q, step_q};
        control_word = cw_q;
        routine      = routine_q;
        step         = step_q;
        sync         = sync_q;
        nmi_taken    = nmi_taken_q;
        ucode_err    = err_q;
    end
endmodule

// File: tb/tb_microcode_sequencer.sv
// Self-checking bench for microcode_sequencer: a small behavioural ROM, a
// table of per-cycle vectors with hand-computed expectations, and directed
// sequences for asynchronous reset and END on the last step.
module tb_microcode_sequencer;
    logic        fclk = 1'b0;
    logic        reset;
    logic        clock_running;
    logic [7:0]  opcode;
    logic        nmi_req;
    logic        irq_req;
    logic        irq_mask;
    logic [62:0] control_word;
    logic [8:0]  routine;
    logic [3:0]  step;
    logic        sync;
    logic        nmi_taken;
    logic        ucode_err;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 fclk = ~fclk;

    microcode_sequencer_if #(.ADDR_W(13), .DATA_W(64)) rom_bus ();

    microcode_sequencer #(
        .OP_BITS  (8),
        .STEP_BITS(4),
        .CW_WIDTH (63),
        .CW_IDLE  (63'h0)
    ) dut (
        .fclk         (fclk),
        .reset        (reset),
        .clock_running(clock_running),
        .opcode       (opcode),
        .nmi_req      (nmi_req),
        .irq_req      (irq_req),
        .irq_mask     (irq_mask),
        .rom          (rom_bus.master),
        .control_word (control_word),
        .routine      (routine),
        .step         (step),
        .sync         (sync),
        .nmi_taken    (nmi_taken),
        .ucode_err    (ucode_err)
    );

    // Behavioural ROM: END step per routine (16 = never), word derived from address.
    function automatic int end_step(input logic [8:0] r);
        case (r)
            9'h100:  return 6;
            9'h101:  return 2;
            9'h102:  return 1;
            9'h0A9:  return 3;
            9'h0EA:  return 0;
            9'h000:  return 16;
            9'h00F:  return 15;
            default: return 1;
        endcase
    endfunction

    function automatic logic [62:0] cw_of(input logic [12:0] a);
        return {50'h2AAAAAAAAAAAA, a} ^ {a, 50'h0};
    endfunction

    assign rom_bus.rom_data = {(int'(rom_bus.rom_addr[3:0]) == end_step(rom_bus.rom_addr[12:4])),
                               cw_of(rom_bus.rom_addr)};

    typedef struct {
        logic       cr;
        logic [7:0] op;
        logic       nmi;
        logic       irq;
        logic       mask;
        logic [8:0] r;
        logic [3:0] s;
        logic       sy;
        logic       nt;
        logic       er;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic cr, input logic [7:0] op, input logic nmi,
                                input logic irq, input logic mask, input logic [8:0] r,
                                input logic [3:0] s, input logic sy, input logic nt,
                                input logic er);
        vec_t v;
        v.cr = cr; v.op = op; v.nmi = nmi; v.irq = irq; v.mask = mask;
        v.r = r; v.s = s; v.sy = sy; v.nt = nt; v.er = er;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_state(input string tag, input logic [8:0] r, input logic [3:0] s,
                             input logic sy, input logic nt, input logic er,
                             input logic [62:0] cw);
        chk({tag, ".routine"},   64'(routine),          64'(r));
        chk({tag, ".step"},      64'(step),             64'(s));
        chk({tag, ".rom_addr"},  64'(rom_bus.rom_addr), 64'({r, s}));
        chk({tag, ".sync"},      64'(sync),             64'(sy));
        chk({tag, ".nmi_taken"}, 64'(nmi_taken),        64'(nt));
        chk({tag, ".ucode_err"}, 64'(ucode_err),        64'(er));
        chk({tag, ".cw"},        64'(control_word),     64'(cw));
    endtask

    initial begin
        logic [8:0]  prev_r;
        logic [3:0]  prev_s;
        logic [62:0] exp_cw;

        reset = 1'b1; clock_running = 1'b1; opcode = 8'hA9;
        nmi_req = 1'b0; irq_req = 1'b0; irq_mask = 1'b0;

        // ---- vector table ----
        for (int i = 1; i <= 6; i++) add(1, 8'hA9, 0, 0, 0, 9'h100, 4'(i), 0, 0, 0);
        add(1, 8'hA9, 0, 0, 0, 9'h0A9, 0, 1, 0, 0);   // RESET END -> opcode A9
        add(1, 8'hA9, 0, 0, 0, 9'h0A9, 1, 0, 0, 0);
        add(1, 8'hA9, 0, 0, 0, 9'h0A9, 2, 0, 0, 0);
        add(1, 8'hA9, 1, 0, 0, 9'h0A9, 3, 0, 0, 0);   // NMI pulse at step 2
        add(1, 8'hA9, 0, 0, 0, 9'h101, 0, 0, 1, 0);   // NMI entered
        add(1, 8'hA9, 1, 0, 0, 9'h101, 1, 0, 0, 0);   // second pulse inside NMI
        add(1, 8'hA9, 0, 0, 0, 9'h101, 2, 0, 0, 0);
        add(1, 8'hA9, 0, 0, 0, 9'h101, 0, 0, 1, 0);   // NMI again
        add(1, 8'hA9, 0, 0, 0, 9'h101, 1, 0, 0, 0);
        add(1, 8'hA9, 0, 0, 0, 9'h101, 2, 0, 0, 0);
        add(1, 8'hEA, 0, 1, 1, 9'h0EA, 0, 1, 0, 0);   // masked IRQ ignored
        add(1, 8'hEA, 0, 1, 0, 9'h102, 0, 0, 0, 0);   // 1-step opcode, IRQ taken
        add(1, 8'hEA, 1, 1, 0, 9'h102, 1, 0, 0, 0);   // NMI edge while IRQ held
        add(1, 8'hEA, 0, 1, 0, 9'h101, 0, 0, 1, 0);   // NMI wins over IRQ
        add(1, 8'hEA, 0, 1, 0, 9'h101, 1, 0, 0, 0);
        add(1, 8'hEA, 0, 1, 0, 9'h101, 2, 0, 0, 0);
        add(1, 8'hEA, 0, 1, 0, 9'h102, 0, 0, 0, 0);   // IRQ after NMI
        add(1, 8'h00, 0, 0, 0, 9'h102, 1, 0, 0, 0);
        add(1, 8'h00, 0, 0, 0, 9'h000, 0, 1, 0, 0);   // IRQ dropped -> opcode 00
        for (int i = 1; i <= 15; i++) add(1, 8'h00, 0, 0, 0, 9'h000, 4'(i), 0, 0, 0);
        add(1, 8'h0F, 0, 0, 0, 9'h00F, 0, 1, 0, 1);   // forced end sets ucode_err
        for (int i = 1; i <= 4; i++) add(1, 8'h0F, 0, 0, 0, 9'h00F, 4'(i), 0, 0, 1);
        add(0, 8'h0F, 1, 0, 0, 9'h00F, 4, 0, 0, 1);   // stall, NMI edge latched
        for (int i = 0; i < 4; i++) add(0, 8'h0F, 0, 0, 0, 9'h00F, 4, 0, 0, 1);
        for (int i = 5; i <= 15; i++) add(1, 8'h0F, 0, 0, 0, 9'h00F, 4'(i), 0, 0, 1);
        add(1, 8'h0F, 0, 0, 0, 9'h101, 0, 0, 1, 1);   // stalled NMI taken at END
        add(1, 8'h0F, 0, 0, 0, 9'h101, 1, 0, 0, 1);
        add(1, 8'h0F, 0, 0, 0, 9'h101, 2, 0, 0, 1);
        add(1, 8'hEA, 0, 0, 0, 9'h0EA, 0, 1, 0, 1);

        // ---- reset state ----
        repeat (2) @(negedge fclk);
        chk_state("reset", 9'h100, 4'h0, 0, 0, 0, 63'h0);
        reset = 1'b0;

        prev_r = 9'h100; prev_s = 4'h0; exp_cw = 63'h0;
        for (int i = 0; i < vecs.size(); i++) begin
            clock_running = vecs[i].cr; opcode = vecs[i].op; nmi_req = vecs[i].nmi;
            irq_req = vecs[i].irq; irq_mask = vecs[i].mask;
            if (vecs[i].cr) exp_cw = cw_of({prev_r, prev_s});
            @(posedge fclk);
            #1;
            chk_state($sformatf("vec%0d", i), vecs[i].r, vecs[i].s, vecs[i].sy,
                      vecs[i].nt, vecs[i].er, exp_cw);
            prev_r = vecs[i].r; prev_s = vecs[i].s;
            @(negedge fclk);
        end

        // ---- asynchronous reset mid-routine at step 3 ----
        clock_running = 1'b1; nmi_req = 1'b0; irq_req = 1'b0; opcode = 8'hA9;
        reset = 1'b1;
        @(negedge fclk);
        chk("rst2.err_cleared", 64'(ucode_err), 64'(0));
        reset = 1'b0;
        repeat (10) @(posedge fclk);
        #2;
        chk_state("pre_async", 9'h0A9, 4'h3, 0, 0, 0, cw_of({9'h0A9, 4'h2}));
        reset = 1'b1;
        #1;
        chk_state("async_rst", 9'h100, 4'h0, 0, 0, 0, 63'h0);

        // ---- END exactly on step 15 does not flag an error ----
        @(negedge fclk);
        opcode = 8'h0F;
        reset = 1'b0;
        repeat (7) @(posedge fclk);
        #1;
        chk("end15.enter_routine", 64'(routine), 64'(9'h00F));
        opcode = 8'hEA;
        repeat (16) @(posedge fclk);
        #1;
        chk_state("end15", 9'h0EA, 4'h0, 1, 0, 0, cw_of({9'h00F, 4'hF}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
